serial_to_frame: RTL and testbench

- Receive-side counterpart of the frame serialiser.
- Accepts the byte stream of 16-byte frames and hunts for the periodic status/sync frame to gain alignment.
- Reassembles 128-bit data frames and hands them downstream with a ready/next handshake, and decodes status frames into stats registers.
- Also generates the two-byte width command ('w', 0xA0|width) travelling back toward the serialiser.

---
 rtl/frame_pkg.sv | 31 +++
 rtl/width_cmd_tx.sv | 84 ++++++++
 rtl/serial_to_frame.sv | 164 ++++++++++++++++
 tb/tb_serial_to_frame.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants, field positions and state encodings for the frame receiver
package frame_pkg;

  localparam logic [7:0]  SYNC_HEADER    = 8'hA6;
  localparam logic [31:0] SYNC_TRAILER   = 32'hFFFFFF7F;

  localparam logic [7:0]  CMD_PREFIX     = 8'h77;
  localparam logic [7:0]  CMD_WIDTH_BASE = 8'hA0;

  // Status frame field LSB positions within the 128-bit frame
  localparam int STAT_CNT_LSB   = 104;
  localparam int STAT_LEDS_LSB  = 80;
  localparam int STAT_LOST_LSB  = 64;
  localparam int STAT_TOTAL_LSB = 32;

  typedef enum logic {
    RX_HUNT   = 1'b0,
    RX_LOCKED = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_PREFIX = 2'd1,
    C_ARG    = 2'd2
  } cmd_state_e;

  function automatic logic is_status_frame(input logic [7:0] hdr, input logic [31:0] trl);
    return (hdr == SYNC_HEADER) && (trl == SYNC_TRAILER);
  endfunction

endpackage

// File: rtl/width_cmd_tx.sv
// rtl/width_cmd_tx.sv - two-byte width command generator with a single latest-wins pending slot
module width_cmd_tx
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] WidthReq,
  input  logic       WidthReqValid,
  output logic [7:0] TxVal,
  output logic       TxReady,
  input  logic       TxNext,
  output logic       TxBusy
);

  cmd_state_e state_q, state_d;
  logic [1:0] width_q, width_d;
  logic       pend_q, pend_d;
  logic [1:0] pend_width_q, pend_width_d;

  // Command state, the width being sent and the pending request slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      width_q      <= 2'd0;
      pend_q       <= 1'b0;
      pend_width_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      pend_q       <= pend_d;
      pend_width_q <= pend_width_d;
    end
  end

  // Next state, pending-slot update and the byte presented to the sink
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    pend_d       = pend_q;
    pend_width_d = pend_width_q;
    TxVal        = 8'h00;
    TxReady      = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (WidthReqValid) begin
          state_d = C_PREFIX;
          width_d = WidthReq;
        end
      end
      C_PREFIX: begin
        TxVal   = CMD_PREFIX;
        TxReady = 1'b1;
        if (WidthReqValid) begin
          pend_d       = 1'b1;
          pend_width_d = WidthReq;
        end
        if (TxNext) begin
          state_d = C_ARG;
        end
      end
      C_ARG: begin
        TxVal   = CMD_WIDTH_BASE | {6'd0, width_q};
        TxReady = 1'b1;
        // A request arriving on the completing cycle still wins over an older pending one
        if (WidthReqValid) begin
          pend_d       = 1'b1;
          pend_width_d = WidthReq;
        end
        if (TxNext) begin
          if (pend_d) begin
            state_d = C_PREFIX;
            width_d = pend_width_d;
            pend_d  = 1'b0;
          end else begin
            state_d = C_IDLE;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
    TxBusy = (state_q != C_IDLE) || pend_q;
  end

endmodule

// File: rtl/serial_to_frame.sv
// rtl/serial_to_frame.sv - byte-stream frame aligner, data frame reassembly and status decode
module serial_to_frame
  import frame_pkg::*;
#(
  parameter int BUFFLENLOG2 = 9,
  parameter int NOSYNC_LOG2 = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             RxVal,
  input  logic                   RxStrobe,
  output logic [127:0]           Frame,
  output logic                   FrameReady,
  input  logic                   FrameNext,
  output logic                   Locked,
  output logic                   StatusValid,
  output logic [BUFFLENLOG2-1:0] RemoteFramesCnt,
  output logic [7:0]             Leds,
  output logic [15:0]            LostFrames,
  output logic [31:0]            TotalFrames,
  output logic [15:0]            DroppedFrames,
  input  logic [1:0]             WidthReq,
  input  logic                   WidthReqValid,
  output logic [7:0]             TxVal,
  output logic                   TxReady,
  input  logic                   TxNext,
  output logic                   TxBusy
);

  localparam logic [NOSYNC_LOG2-1:0] NOSYNC_MAX = '1;
  localparam logic [NOSYNC_LOG2-1:0] NOSYNC_ONE = {{(NOSYNC_LOG2-1){1'b0}}, 1'b1};

  rx_state_e              rx_state_q, rx_state_d;
  logic [127:0]           shift_q, shift_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [NOSYNC_LOG2-1:0] nosync_q, nosync_d;
  logic [127:0]           frame_q, frame_d;
  logic                   frame_ready_q, frame_ready_d;
  logic [15:0]            dropped_q, dropped_d;
  logic                   status_valid_q, status_valid_d;
  logic [BUFFLENLOG2-1:0] remote_cnt_q, remote_cnt_d;
  logic [7:0]             leds_q, leds_d;
  logic [15:0]            lost_q, lost_d;
  logic [31:0]            total_q, total_d;

  logic [127:0]           shift_in;
  logic                   sync_match;
  logic                   load_stats;

  // The window as it will look once the current byte is shifted in
  assign shift_in   = {shift_q[119:0], RxVal};
  assign sync_match = is_status_frame(shift_in[127:120], shift_in[31:0]);

  // Receive-path registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= RX_HUNT;
      shift_q        <= '0;
      byte_cnt_q     <= 4'd0;
      nosync_q       <= '0;
      frame_q        <= '0;
      frame_ready_q  <= 1'b0;
      dropped_q      <= 16'd0;
      status_valid_q <= 1'b0;
      remote_cnt_q   <= '0;
      leds_q         <= 8'd0;
      lost_q         <= 16'd0;
      total_q        <= 32'd0;
    end else begin
      rx_state_q     <= rx_state_d;
      shift_q        <= shift_d;
      byte_cnt_q     <= byte_cnt_d;
      nosync_q       <= nosync_d;
      frame_q        <= frame_d;
      frame_ready_q  <= frame_ready_d;
      dropped_q      <= dropped_d;
      status_valid_q <= status_valid_d;
      remote_cnt_q   <= remote_cnt_d;
      leds_q         <= leds_d;
      lost_q         <= lost_d;
      total_q        <= total_d;
    end
  end

  // Alignment hunt, frame boundary tracking, data hand-off and status decode
  always_comb begin
    rx_state_d     = rx_state_q;
    shift_d        = shift_q;
    byte_cnt_d     = byte_cnt_q;
    nosync_d       = nosync_q;
    frame_d        = frame_q;
    frame_ready_d  = frame_ready_q & ~FrameNext;
    dropped_d      = dropped_q;
    status_valid_d = 1'b0;
    remote_cnt_d   = remote_cnt_q;
    leds_d         = leds_q;
    lost_d         = lost_q;
    total_d        = total_q;
    load_stats     = 1'b0;

    if (RxStrobe) begin
      shift_d = shift_in;
      if (rx_state_q == RX_HUNT) begin
        if (sync_match) begin
          rx_state_d = RX_LOCKED;
          byte_cnt_d = 4'd0;
          nosync_d   = '0;
          load_stats = 1'b1;
        end
      end else begin
        byte_cnt_d = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'd15) begin
          if (sync_match) begin
            load_stats = 1'b1;
            nosync_d   = '0;
          end else begin
            // Consumer freeing the slot on this same cycle lets the new frame in
            if (!frame_ready_q || FrameNext) begin
              frame_d       = shift_in;
              frame_ready_d = 1'b1;
            end else if (dropped_q != 16'hFFFF) begin
              dropped_d = dropped_q + 16'd1;
            end
            nosync_d = nosync_q + NOSYNC_ONE;
            if (nosync_d == NOSYNC_MAX) begin
              rx_state_d = RX_HUNT;
              nosync_d   = '0;
            end
          end
        end
      end
    end

    if (load_stats) begin
      status_valid_d = 1'b1;
      remote_cnt_d   = shift_in[STAT_CNT_LSB +: BUFFLENLOG2];
      leds_d         = shift_in[STAT_LEDS_LSB +: 8];
      lost_d         = shift_in[STAT_LOST_LSB +: 16];
      total_d        = shift_in[STAT_TOTAL_LSB +: 32];
    end
  end

  assign Frame           = frame_q;
  assign FrameReady      = frame_ready_q;
  assign Locked          = (rx_state_q == RX_LOCKED);
  assign StatusValid     = status_valid_q;
  assign RemoteFramesCnt = remote_cnt_q;
  assign Leds            = leds_q;
  assign LostFrames      = lost_q;
  assign TotalFrames     = total_q;
  assign DroppedFrames   = dropped_q;

  width_cmd_tx u_cmd (
    .clk           (clk),
    .rst_n         (rst_n),
    .WidthReq      (WidthReq),
    .WidthReqValid (WidthReqValid),
    .TxVal         (TxVal),
    .TxReady       (TxReady),
    .TxNext        (TxNext),
    .TxBusy        (TxBusy)
  );

endmodule

// File: tb/tb_serial_to_frame.sv
// tb/tb_serial_to_frame.sv - self-checking bench for serial_to_frame
module tb_serial_to_frame;

  localparam int BL = 9;
  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    RxVal = 8'h00;
  logic          RxStrobe = 1'b0;
  logic [127:0]  Frame;
  logic          FrameReady;
  logic          FrameNext = 1'b0;
  logic          Locked;
  logic          StatusValid;
  logic [BL-1:0] RemoteFramesCnt;
  logic [7:0]    Leds;
  logic [15:0]   LostFrames;
  logic [31:0]   TotalFrames;
  logic [15:0]   DroppedFrames;
  logic [1:0]    WidthReq = 2'd0;
  logic          WidthReqValid = 1'b0;
  logic [7:0]    TxVal;
  logic          TxReady;
  logic          TxNext = 1'b0;
  logic          TxBusy;

  serial_to_frame #(.BUFFLENLOG2(BL), .NOSYNC_LOG2(NL)) dut (
    .clk(clk), .rst_n(rst_n), .RxVal(RxVal), .RxStrobe(RxStrobe),
    .Frame(Frame), .FrameReady(FrameReady), .FrameNext(FrameNext),
    .Locked(Locked), .StatusValid(StatusValid), .RemoteFramesCnt(RemoteFramesCnt),
    .Leds(Leds), .LostFrames(LostFrames), .TotalFrames(TotalFrames),
    .DroppedFrames(DroppedFrames), .WidthReq(WidthReq), .WidthReqValid(WidthReqValid),
    .TxVal(TxVal), .TxReady(TxReady), .TxNext(TxNext), .TxBusy(TxBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: window of the last 16 bytes, bytes since lock, data frames since status
  logic [127:0]  m_win, m_frame;
  logic          m_locked, m_ready, m_sv;
  int            m_since, m_nodata;
  logic [15:0]   m_drop, m_lost;
  logic [BL-1:0] m_cnt;
  logic [7:0]    m_leds;
  logic [31:0]   m_total;

  task automatic model_reset();
    m_win = '0; m_frame = '0; m_locked = 0; m_ready = 0; m_sv = 0;
    m_since = 0; m_nodata = 0; m_drop = 0; m_lost = 0; m_cnt = '0; m_leds = 0; m_total = 0;
  endtask

  task automatic take_stats();
    m_cnt   = m_win[104 +: BL];
    m_leds  = m_win[87:80];
    m_lost  = m_win[79:64];
    m_total = m_win[63:32];
  endtask

  task automatic model_step(input logic s, input logic [7:0] v, input logic nx);
    logic rdy_next, st, sv;
    rdy_next = m_ready && !nx;
    sv = 1'b0;
    if (s) begin
      m_win = {m_win[119:0], v};
      st = (m_win[127:120] == 8'hA6) && (m_win[31:0] == 32'hFFFFFF7F);
      if (!m_locked) begin
        if (st) begin
          m_locked = 1; m_since = 0; m_nodata = 0; take_stats(); sv = 1;
        end
      end else begin
        m_since++;
        if (m_since % 16 == 0) begin
          if (st) begin
            take_stats(); sv = 1; m_nodata = 0;
          end else begin
            if (!m_ready || nx) begin
              m_frame = m_win; rdy_next = 1;
            end else if (m_drop != 16'hFFFF) begin
              m_drop++;
            end
            m_nodata++;
            if (m_nodata == (1 << NL) - 1) begin
              m_locked = 0; m_nodata = 0;
            end
          end
        end
      end
    end
    m_ready = rdy_next;
    m_sv = sv;
  endtask

  task automatic compare_rx();
    chk("Locked", 128'(Locked), 128'(m_locked));
    chk("FrameReady", 128'(FrameReady), 128'(m_ready));
    chk("Frame", Frame, m_frame);
    chk("DroppedFrames", 128'(DroppedFrames), 128'(m_drop));
    chk("StatusValid", 128'(StatusValid), 128'(m_sv));
    chk("RemoteFramesCnt", 128'(RemoteFramesCnt), 128'(m_cnt));
    chk("Leds", 128'(Leds), 128'(m_leds));
    chk("LostFrames", 128'(LostFrames), 128'(m_lost));
    chk("TotalFrames", 128'(TotalFrames), 128'(m_total));
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge
  task automatic cyc(input logic s, input logic [7:0] v, input logic nx);
    RxStrobe = s; RxVal = v; FrameNext = nx;
    model_step(s, v, nx);
    @(negedge clk);
    compare_rx();
  endtask

  task automatic send_frame(input logic [127:0] f, input logic nx_body, input logic nx_last);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, f[127-8*i -: 8], (i == 15) ? nx_last : nx_body);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " Frame"}, Frame, 128'd0);
    chk({tag, " FrameReady"}, 128'(FrameReady), 128'd0);
    chk({tag, " Locked"}, 128'(Locked), 128'd0);
    chk({tag, " StatusValid"}, 128'(StatusValid), 128'd0);
    chk({tag, " RemoteFramesCnt"}, 128'(RemoteFramesCnt), 128'd0);
    chk({tag, " Leds"}, 128'(Leds), 128'd0);
    chk({tag, " LostFrames"}, 128'(LostFrames), 128'd0);
    chk({tag, " TotalFrames"}, 128'(TotalFrames), 128'd0);
    chk({tag, " DroppedFrames"}, 128'(DroppedFrames), 128'd0);
    chk({tag, " TxVal"}, 128'(TxVal), 128'd0);
    chk({tag, " TxReady"}, 128'(TxReady), 128'd0);
    chk({tag, " TxBusy"}, 128'(TxBusy), 128'd0);
  endtask

  typedef struct {
    logic       wrv;
    logic [1:0] wr;
    logic       tn;
    logic [7:0] val;
    logic       rdy;
    logic       busy;
  } cmd_vec_t;

  localparam logic [127:0] ST = {8'hA6, 16'h0005, 16'h0000, 8'h3C, 16'h0002, 32'h00000100, 32'hFFFFFF7F};
  localparam logic [127:0] SEQ = 128'h000102030405060708090A0B0C0D0E0F;

  initial begin
    cmd_vec_t cv[$];
    logic [127:0] f1, f4, f;
    int kind, n;
    logic nx;

    // Command vectors: inputs applied for one cycle, outputs expected after that edge
    cv.push_back('{1'b1, 2'd2, 1'b1, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b1, 2'd1, 1'b1, 8'hA2, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'hA1, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0});
    cv.push_back('{1'b1, 2'd2, 1'b0, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b0, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b1, 2'd1, 1'b0, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b1, 2'd3, 1'b0, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'hA2, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b0, 8'hA2, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'hA3, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0});
    cv.push_back('{1'b1, 2'd2, 1'b1, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b1, 2'd1, 1'b1, 8'hA2, 1'b1, 1'b1});
    cv.push_back('{1'b1, 2'd3, 1'b1, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'hA3, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0});
    cv.push_back('{1'b1, 2'd0, 1'b0, 8'h77, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'hA0, 1'b1, 1'b1});
    cv.push_back('{1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0});

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random junk, then the first status frame locks
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0);
    send_frame(ST, 1'b0, 1'b0);
    chk("lock Locked", 128'(Locked), 128'd1);
    chk("lock StatusValid", 128'(StatusValid), 128'd1);
    chk("lock RemoteFramesCnt", 128'(RemoteFramesCnt), 128'd5);
    chk("lock Leds", 128'(Leds), 128'h3C);
    chk("lock LostFrames", 128'(LostFrames), 128'd2);
    chk("lock TotalFrames", 128'(TotalFrames), 128'h100);
    cyc(1'b0, 8'h00, 1'b0);
    chk("status pulse width", 128'(StatusValid), 128'd0);

    // Data frame with FrameNext held high
    send_frame(SEQ, 1'b1, 1'b1);
    chk("seq FrameReady", 128'(FrameReady), 128'd1);
    chk("seq Frame", Frame, SEQ);
    cyc(1'b0, 8'h00, 1'b1);
    chk("seq consumed", 128'(FrameReady), 128'd0);
    chk("seq DroppedFrames", 128'(DroppedFrames), 128'd0);

    // Overflow: later frames dropped while the first is held
    f1 = {16{8'h11}};
    f4 = {16{8'h44}};
    send_frame(ST, 1'b0, 1'b0);
    send_frame(f1, 1'b0, 1'b0);
    send_frame({16{8'h22}}, 1'b0, 1'b0);
    send_frame(ST, 1'b0, 1'b0);
    send_frame({16{8'h33}}, 1'b0, 1'b0);
    chk("drop Frame kept", Frame, f1);
    chk("drop DroppedFrames", 128'(DroppedFrames), 128'd2);
    send_frame(f4, 1'b0, 1'b1);
    chk("next+load Frame", Frame, f4);
    chk("next+load FrameReady", 128'(FrameReady), 128'd1);

    // Loss of lock after 2^NL-1 data frames without status
    send_frame(ST, 1'b0, 1'b0);
    send_frame(SEQ, 1'b0, 1'b1);
    send_frame(f1, 1'b0, 1'b1);
    chk("nosync still Locked", 128'(Locked), 128'd1);
    send_frame(f4, 1'b0, 1'b1);
    chk("nosync unlock", 128'(Locked), 128'd0);
    send_frame(ST, 1'b0, 1'b0);
    chk("relock", 128'(Locked), 128'd1);
    cyc(1'b0, 8'h00, 1'b1);

    // Command path vectors
    for (int i = 0; i < cv.size(); i++) begin
      WidthReqValid = cv[i].wrv; WidthReq = cv[i].wr; TxNext = cv[i].tn;
      @(negedge clk);
      chk($sformatf("cmd[%0d] TxReady", i), 128'(TxReady), 128'(cv[i].rdy));
      chk($sformatf("cmd[%0d] TxBusy", i), 128'(TxBusy), 128'(cv[i].busy));
      if (cv[i].rdy) chk($sformatf("cmd[%0d] TxVal", i), 128'(TxVal), 128'(cv[i].val));
    end
    WidthReqValid = 1'b0; TxNext = 1'b0;

    // Reset in the middle of a frame and of a command
    send_frame(ST, 1'b0, 1'b0);
    send_frame(SEQ, 1'b0, 1'b0);
    WidthReq = 2'd2; WidthReqValid = 1'b1;
    cyc(1'b1, 8'h50, 1'b0);
    WidthReqValid = 1'b0;
    for (int i = 1; i < 7; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    chk("pre-reset TxReady", 128'(TxReady), 128'd1);
    chk("pre-reset FrameReady", 128'(FrameReady), 128'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 7; i < 16; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    chk("post-reset FrameReady", 128'(FrameReady), 128'd0);
    chk("post-reset Locked", 128'(Locked), 128'd0);
    chk("post-reset TxReady", 128'(TxReady), 128'd0);

    // Randomized stream: status frames, data frames, junk and gaps
    for (int u = 0; u < 220; u++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2)
        f = {8'hA6, 16'($urandom), 16'($urandom), 8'($urandom), 16'($urandom), 32'($urandom), 32'hFFFFFF7F};
      else
        f = {$urandom, $urandom, $urandom, $urandom};
      n = (kind == 2) ? $urandom_range(1, 3) : 16;
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          nx = ($urandom_range(0, 2) == 0);
          cyc(1'b0, 8'h00, nx);
        end
        nx = ($urandom_range(0, 2) == 0);
        cyc(1'b1, f[127-8*i -: 8], nx);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
